saber_polymul_param: RTL and testbench
======================================

Name: saber_polymul_param

Overview:
- Parametrised successor to the 256-coefficient Saber schoolbook multiplier.
- Computes r = a·s in Z_(2^QW)[x]/(x^N+1):
  - a is a public polynomial, QW-bit coefficients, bit-packed into WORD-bit memory words.
  - s is a small secret, SW-bit sign-magnitude coefficients.
- Optionally accumulates onto the previous result, for matrix-vector inner products.
- Reads both operands from external ROM/BRAM with 1-cycle read latency and streams the result out one coefficient per cycle.

Parameters:
- N, 256, polynomial degree; power of two, ≥16.
- QW, 13, public/result coefficient width; arithmetic is mod 2^QW; QW < WORD.
- SW, 4, secret coefficient width: MSB = sign, SW-1 magnitude bits.
- WORD, 64, memory word width; WORD % SW == 0; (N*QW) % WORD == 0.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- acc_clear  in  1  sampled with start: 1 = zero accumulators, 0 = accumulate onto held result.
- s_address  out  $clog2(N*SW/WORD)  secret word address.
- s_word  in  WORD  secret word; valid 1 cycle after s_address.
- a_address  out  $clog2(N*QW/WORD)  public word address.
- a_word  in  WORD  public word; valid 1 cycle after a_address.
- busy  out  1  high from the cycle after start until done.
- res_valid  out  1  result coefficient strobe.
- res_index  out  $clog2(N)  index of res_coeff.
- res_coeff  out  QW  result coefficient.
- done  out  1  one-cycle pulse after the last result.

Behaviour:
- Reset values: all outputs 0; accumulators, s register and unpacker cleared; FSM in IDLE.
- Packing:
  - Secret coefficient j occupies s_word[(j%(WORD/SW))*SW +: SW] of word j/(WORD/SW).
  - Public stream is word w at stream bits [WORD*w +: WORD]; coefficient i is at stream bits [i*QW +: QW], so coefficients may straddle words.
- Secret decode:
  - Value = (sign ? -mag : mag).
  - 4'b1000 (negative zero) is treated as 0.
- FSM states:
  - IDLE: on start, latch acc_clear; if 1, zero all N accumulators; go to LOAD_S.
  - LOAD_S:
    - Issue s_address 0..N*SW/WORD-1, one per cycle; capture each word the following cycle.
    - Start prefetching a_address 0 in the last issue cycle.
    - Then go to MAC.
  - MAC:
    - Uses a 2-word unpacker buffer and a counter i = 0..N-1.
    - Each cycle a full QW-bit coefficient a_i is available: for every k, acc[k] += a_i * srot[k] mod 2^QW.
    - Then rotate srot: srot'[k] = srot[k-1]; srot'[0] = srot[N-1] with sign bit inverted (multiply by x).
    - A cycle with fewer than QW valid buffered bits is a stall: no accumulate, no rotate.
    - The unpacker issues the next a_address whenever the buffer holds ≤ WORD bits and words remain.
    - After i = N-1 go to DRAIN.
  - DRAIN: res_valid = 1 for N consecutive cycles, res_index 0..N-1, res_coeff = acc[res_index]; then done pulse for 1 cycle; return to IDLE.
- Accumulators persist after DRAIN until the next start with acc_clear = 1, or reset.
- Latency bound: start to done ≤ N*SW/WORD + N + ceil(N*QW/WORD) + N + 4 cycles.
- Boundary conditions:
  - start while busy: ignored.
  - acc_clear outside IDLE: ignored.
  - Reset mid-operation: immediate return to IDLE; all state and outputs cleared; the next start behaves as after power-up.
  - Arithmetic wraps mod 2^QW; negation is two's complement mod 2^QW.

Optional Feature:
- Macro POLMUL_SUB_EN.
- With it: extra input port `subtract` (1 bit), sampled with start. When 1, MAC performs acc[k] -= a_i*srot[k] mod 2^QW, for computing b - A·s style terms.
- Without it: no port; always add.

Test Plan:
- s_0 = +1 (word0 = 64'h1), others 0; a_i = i; acc_clear = 1 -> res_coeff[i] = i for i = 0..255; done within bound.
- s_1 = +1 (s word0 = 64'h10); a_i = i -> r_0 = 8192-255 = 7937; r_k = k-1 for k ≥ 1.
- s_0 = -1 (4'b1001); a_i = i+1 -> r_i = 8192-(i+1); s_0 = 4'b1000 -> all r_i = 0.
- Run the previous identity case twice, second start with acc_clear = 0 -> r_i = 2i mod 8192. Third run with acc_clear = 1 -> r_i = i.
- Assert rst during MAC at i ≈ 100 -> outputs 0 in the same cycle; restart gives correct identity result. start pulsed during LOAD_S/DRAIN -> no effect.
- Random a, s (sign-magnitude, |s| ≤ 5), N = 256 and N = 64 builds, with and without POLMUL_SUB_EN -> all coefficients match a golden negacyclic model.

Source files
------------

// File: rtl/saber_polymul_param.sv
// Negacyclic schoolbook multiplier r = a*s in Z_(2^QW)[x]/(x^N+1): operands come from 1-cycle ROMs, one result coefficient streams out per cycle.
// Optional macro POLMUL_SUB_EN adds a 'subtract' input (sampled with start) that makes the MAC subtract instead of add.
module saber_polymul_param #(
    parameter int N    = 256,
    parameter int QW   = 13,
    parameter int SW   = 4,
    parameter int WORD = 64,
    localparam int S_WORDS = N * SW / WORD,
    localparam int A_WORDS = N * QW / WORD,
    localparam int SAW     = (S_WORDS > 1) ? $clog2(S_WORDS) : 1,
    localparam int AAW     = (A_WORDS > 1) ? $clog2(A_WORDS) : 1,
    localparam int IW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            acc_clear,
`ifdef POLMUL_SUB_EN
    input  logic            subtract,
`endif
    output logic [SAW-1:0]  s_address,
    input  logic [WORD-1:0] s_word,
    output logic [AAW-1:0]  a_address,
    input  logic [WORD-1:0] a_word,
    output logic            busy,
    output logic            res_valid,
    output logic [IW-1:0]   res_index,
    output logic [QW-1:0]   res_coeff,
    output logic            done
);
    localparam int CPW = WORD / SW;
    localparam int BW  = 2 * WORD;
    localparam int CW  = $clog2(BW + 1);
    localparam int NW  = $clog2(A_WORDS + 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_MAC, ST_DRAIN, ST_FIN} state_t;

    state_t         state_q, state_d;
    logic [SAW-1:0] s_addr_q, s_addr_d, s_widx_q, s_widx_d;
    logic           s_req_q, s_req_d, s_vld_q, s_vld_d;
    logic [AAW-1:0] a_addr_q, a_addr_d;
    logic           a_req_q, a_req_d, a_vld_q, a_vld_d;
    logic [NW-1:0]  a_next_q, a_next_d;
    logic [BW-1:0]  buf_q, buf_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           sub_q, sub_d;
    logic           busy_q, busy_d, res_valid_q, res_valid_d, done_q, done_d;
    logic [IW-1:0]  res_index_q, res_index_d;
    logic [QW-1:0]  res_coeff_q, res_coeff_d;
    logic [QW-1:0]  acc_q [N];
    logic [QW-1:0]  acc_d [N];
    logic [SW-1:0]  srot_q [N];
    logic [SW-1:0]  srot_d [N];
    logic [SW-1:0]  s_coef [CPW];
    logic           sub_in;

`ifdef POLMUL_SUB_EN
    assign sub_in = subtract;
`else
    assign sub_in = 1'b0;
`endif

    for (genvar gi = 0; gi < CPW; gi++) begin : g_sdec
        assign s_coef[gi] = s_word[gi*SW +: SW];
    end

    always_comb begin
        logic          have;
        logic [CW-1:0] cnt_t;
        logic [BW-1:0] buf_t;
        logic [QW-1:0] a_cur;
        logic [QW-1:0] prod;
        logic          neg;
        int            base;

        state_d     = state_q;
        s_addr_d    = s_addr_q;
        s_req_d     = 1'b0;
        s_widx_d    = s_addr_q;
        s_vld_d     = s_req_q;
        a_addr_d    = a_addr_q;
        a_req_d     = 1'b0;
        a_vld_d     = a_req_q;
        a_next_d    = a_next_q;
        idx_d       = idx_q;
        sub_d       = sub_q;
        busy_d      = busy_q;
        res_valid_d = 1'b0;
        res_index_d = '0;
        res_coeff_d = '0;
        done_d      = 1'b0;
        acc_d       = acc_q;
        srot_d      = srot_q;
        prod        = '0;
        neg         = 1'b0;
        base        = 0;

        // Unpacker: consume one coefficient from the bottom, append an arriving word on top.
        have  = (state_q == ST_MAC) && (cnt_q >= CW'(QW));
        a_cur = buf_q[QW-1:0];
        buf_t = have ? (buf_q >> QW) : buf_q;
        cnt_t = have ? (cnt_q - CW'(QW)) : cnt_q;
        if (a_vld_q) begin
            buf_t = buf_t | ({{WORD{1'b0}}, a_word} << cnt_t);
            cnt_t = cnt_t + CW'(WORD);
        end
        buf_d = buf_t;
        cnt_d = cnt_t;

        // The in-flight word is counted so the 2-word buffer can never overflow.
        if (((state_q == ST_MAC) || (state_q == ST_LOAD && a_next_q != '0)) &&
            (a_next_q < NW'(A_WORDS)) &&
            ((int'(cnt_t) + (a_req_q ? WORD : 0)) <= WORD)) begin
            a_req_d  = 1'b1;
            a_addr_d = AAW'(a_next_q);
            a_next_d = a_next_q + 1'b1;
        end

        if (have) begin
            for (int k = 0; k < N; k++) begin
                prod     = a_cur * {{(QW-SW+1){1'b0}}, srot_q[k][SW-2:0]};
                neg      = srot_q[k][SW-1] ^ sub_q;
                acc_d[k] = neg ? (acc_q[k] - prod) : (acc_q[k] + prod);
            end
            srot_d[0] = {~srot_q[N-1][SW-1], srot_q[N-1][SW-2:0]};
            for (int k = 1; k < N; k++) begin
                srot_d[k] = srot_q[k-1];
            end
        end

        if (s_vld_q) begin
            base = int'(s_widx_q) * CPW;
            for (int m = 0; m < CPW; m++) begin
                srot_d[base + m] = s_coef[m];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_LOAD;
                    busy_d   = 1'b1;
                    sub_d    = sub_in;
                    s_addr_d = '0;
                    s_req_d  = 1'b1;
                    idx_d    = '0;
                    buf_d    = '0;
                    cnt_d    = '0;
                    a_next_d = '0;
                    if (acc_clear) begin
                        for (int k = 0; k < N; k++) begin
                            acc_d[k] = '0;
                        end
                    end
                    if (S_WORDS == 1) begin
                        a_req_d  = 1'b1;
                        a_addr_d = '0;
                        a_next_d = NW'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (s_req_q && s_addr_q != SAW'(S_WORDS-1)) begin
                    s_addr_d = s_addr_q + 1'b1;
                    s_req_d  = 1'b1;
                    // Prefetch the first public word alongside the last secret word.
                    if (s_addr_q + 1'b1 == SAW'(S_WORDS-1)) begin
                        a_req_d  = 1'b1;
                        a_addr_d = '0;
                        a_next_d = NW'(1);
                    end
                end
                if (s_vld_q && s_widx_q == SAW'(S_WORDS-1)) begin
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (have) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IW'(N-1)) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                res_valid_d = 1'b1;
                res_index_d = idx_q;
                res_coeff_d = acc_q[idx_q];
                idx_d       = idx_q + 1'b1;
                if (idx_q == IW'(N-1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            s_addr_q    <= '0;
            s_widx_q    <= '0;
            s_req_q     <= 1'b0;
            s_vld_q     <= 1'b0;
            a_addr_q    <= '0;
            a_req_q     <= 1'b0;
            a_vld_q     <= 1'b0;
            a_next_q    <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            sub_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_coeff_q <= '0;
            done_q      <= 1'b0;
            for (int k = 0; k < N; k++) begin
                acc_q[k]  <= '0;
                srot_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            s_addr_q    <= s_addr_d;
            s_widx_q    <= s_widx_d;
            s_req_q     <= s_req_d;
            s_vld_q     <= s_vld_d;
            a_addr_q    <= a_addr_d;
            a_req_q     <= a_req_d;
            a_vld_q     <= a_vld_d;
            a_next_q    <= a_next_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sub_q       <= sub_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_coeff_q <= res_coeff_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            srot_q      <= srot_d;
        end
    end

    assign s_address = s_addr_q;
    assign a_address = a_addr_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_coeff = res_coeff_q;
    assign done      = done_q;

endmodule

// File: tb/tb_saber_polymul_param.sv
// Scoreboard bench for saber_polymul_param: expected coefficients are queued at start and popped as res_valid strobes.
module tb_saber_polymul_param;
    localparam int N       = 256;
    localparam int QW      = 13;
    localparam int SW      = 4;
    localparam int WORD    = 64;
    localparam int S_WORDS = N * SW / WORD;
    localparam int A_WORDS = N * QW / WORD;
    localparam int SAW     = (S_WORDS > 1) ? $clog2(S_WORDS) : 1;
    localparam int AAW     = (A_WORDS > 1) ? $clog2(A_WORDS) : 1;
    localparam int IW      = $clog2(N);
    localparam int MASK    = (1 << QW) - 1;
    localparam int BOUND   = S_WORDS + N + (N*QW + WORD - 1) / WORD + N + 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            acc_clear = 1'b0;
`ifdef POLMUL_SUB_EN
    logic            subtract = 1'b0;
`endif
    logic [SAW-1:0]  s_address;
    logic [WORD-1:0] s_word;
    logic [AAW-1:0]  a_address;
    logic [WORD-1:0] a_word;
    logic            busy, res_valid, done;
    logic [IW-1:0]   res_index;
    logic [QW-1:0]   res_coeff;

    logic [WORD-1:0] s_mem [S_WORDS];
    logic [WORD-1:0] a_mem [A_WORDS];
    int              a_val [N];
    logic [SW-1:0]   s_code [N];
    int              exp_arr [N];
    int              model_acc [N];
    int              exp_idx_q [$];
    int              exp_coef_q [$];
    int              n_tests = 0;
    int              n_fail  = 0;

    saber_polymul_param #(.N(N), .QW(QW), .SW(SW), .WORD(WORD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_clear (acc_clear),
`ifdef POLMUL_SUB_EN
        .subtract  (subtract),
`endif
        .s_address (s_address),
        .s_word    (s_word),
        .a_address (a_address),
        .a_word    (a_word),
        .busy      (busy),
        .res_valid (res_valid),
        .res_index (res_index),
        .res_coeff (res_coeff),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s_word <= s_mem[s_address];
        a_word <= a_mem[a_address];
    end

    task automatic load_mem();
        logic [N*QW-1:0] stream;
        stream = '0;
        for (int i = 0; i < N; i++) stream[i*QW +: QW] = QW'(a_val[i]);
        for (int w = 0; w < A_WORDS; w++) a_mem[w] = stream[w*WORD +: WORD];
        for (int w = 0; w < S_WORDS; w++) s_mem[w] = '0;
        for (int j = 0; j < N; j++) s_mem[j/(WORD/SW)][(j%(WORD/SW))*SW +: SW] = s_code[j];
    endtask

    task automatic set_identity(input int a_off);
        for (int i = 0; i < N; i++) begin
            a_val[i]  = i + a_off;
            s_code[i] = '0;
        end
    endtask

    // Golden negacyclic product, written directly from the definition of x^N = -1.
    task automatic model_expected(input bit clr, input bit sub);
        int r [N];
        int sv;
        for (int k = 0; k < N; k++) r[k] = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sv = s_code[j][SW-1] ? -int'(s_code[j][SW-2:0]) : int'(s_code[j][SW-2:0]);
                if (i + j < N) r[i+j] += a_val[i] * sv;
                else           r[i+j-N] -= a_val[i] * sv;
            end
        end
        for (int k = 0; k < N; k++)
            exp_arr[k] = ((clr ? 0 : model_acc[k]) + (sub ? -r[k] : r[k])) & MASK;
    endtask

    task automatic run_job(input bit clr, input bit sub, input bit glitch, input string name);
        int cyc;
        int nres;
        int ei;
        int ec;
        bit got_done;
        load_mem();
        for (int k = 0; k < N; k++) begin
            exp_idx_q.push_back(k);
            exp_coef_q.push_back(exp_arr[k]);
            model_acc[k] = exp_arr[k];
        end
        @(negedge clk);
        start = 1'b1;
        acc_clear = clr;
`ifdef POLMUL_SUB_EN
        subtract = sub;
`endif
        @(negedge clk);
        start = 1'b0;
        acc_clear = ~clr;
        cyc = 0;
        nres = 0;
        got_done = 1'b0;
        while (!got_done && cyc < BOUND + 20) begin
            @(negedge clk);
            cyc++;
            start = glitch && (cyc == 3 || (res_valid && res_index == IW'(20)));
            if (res_valid) begin
                nres++;
                n_tests++;
                if (exp_idx_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_result: got idx=%0d val=%0d, expected none", name, res_index, res_coeff);
                end else begin
                    ei = exp_idx_q.pop_front();
                    ec = exp_coef_q.pop_front();
                    if (res_index !== IW'(ei) || res_coeff !== QW'(ec)) begin
                        n_fail++;
                        $display("FAIL %s coeff: got idx=%0d val=%0d, expected idx=%0d val=%0d",
                                 name, res_index, res_coeff, ei, ec);
                    end
                end
                if (nres == 1) begin
                    n_tests++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s busy_in_drain: got %0b, expected 1", name, busy);
                    end
                end
            end
            if (done === 1'b1) got_done = 1'b1;
        end
        start = 1'b0;
        n_tests++;
        if (!got_done || cyc > BOUND) begin
            n_fail++;
            $display("FAIL %s latency: got done=%0b after %0d cycles, expected done within %0d", name, got_done, cyc, BOUND);
        end
        n_tests++;
        if (nres != N || exp_idx_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s result_count: got %0d results, expected %0d", name, nres, N);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: got done=%0b busy=%0b, expected 0 0", name, done, busy);
        end
        exp_idx_q.delete();
        exp_coef_q.delete();
        $display("[TB] %s: %0d results, done after %0d cycles", name, nres, cyc);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || res_index !== '0 ||
            res_coeff !== '0 || s_address !== '0 || a_address !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%0b valid=%0b done=%0b idx=%0d coeff=%0d sa=%0d aa=%0d, expected all 0",
                     busy, res_valid, done, res_index, res_coeff, s_address, a_address);
        end
        rst = 1'b0;
        for (int k = 0; k < N; k++) model_acc[k] = 0;
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_identity();
        set_identity(0);
        s_code[0] = 4'b0001;
        for (int i = 0; i < N; i++) exp_arr[i] = i;
        run_job(1'b1, 1'b0, 1'b0, "identity");
    endtask

    task automatic test_shift();
        set_identity(0);
        s_code[1] = 4'b0001;
        exp_arr[0] = 7937;
        for (int k = 1; k < N; k++) exp_arr[k] = k - 1;
        run_job(1'b1, 1'b0, 1'b0, "shift_x");
    endtask

    task automatic test_negate();
        set_identity(1);
        s_code[0] = 4'b1001;
        for (int i = 0; i < N; i++) exp_arr[i] = (8192 - (i + 1)) & MASK;
        run_job(1'b1, 1'b0, 1'b0, "minus_one");
        s_code[0] = 4'b1000;
        for (int i = 0; i < N; i++) exp_arr[i] = 0;
        run_job(1'b1, 1'b0, 1'b0, "neg_zero");
    endtask

    task automatic test_back_to_back();
        set_identity(0);
        s_code[0] = 4'b0001;
        for (int i = 0; i < N; i++) exp_arr[i] = i;
        run_job(1'b1, 1'b0, 1'b0, "acc_first");
        for (int i = 0; i < N; i++) exp_arr[i] = (2 * i) & MASK;
        run_job(1'b0, 1'b0, 1'b1, "acc_second_glitch");
        for (int i = 0; i < N; i++) exp_arr[i] = i;
        run_job(1'b1, 1'b0, 1'b0, "acc_reclear");
    endtask

    task automatic test_reset_mid();
        set_identity(0);
        s_code[0] = 4'b0001;
        s_code[3] = 4'b0010;
        load_mem();
        @(negedge clk);
        start = 1'b1;
        acc_clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S_WORDS + 1 + 100) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got %0b, expected 1", busy);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || res_index !== '0 ||
            res_coeff !== '0 || s_address !== '0 || a_address !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%0b valid=%0b done=%0b idx=%0d coeff=%0d sa=%0d aa=%0d, expected all 0",
                     busy, res_valid, done, res_index, res_coeff, s_address, a_address);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < N; k++) model_acc[k] = 0;
        $display("[TB] reset_mid: reset asserted during MAC");
        // Accumulate mode on purpose: reset alone must have zeroed the accumulators.
        set_identity(0);
        s_code[0] = 4'b0001;
        for (int i = 0; i < N; i++) exp_arr[i] = i;
        run_job(1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic randomize_operands();
        int mag;
        int sgn;
        for (int i = 0; i < N; i++) begin
            a_val[i]  = int'($urandom_range(0, MASK));
            mag       = int'($urandom_range(0, 5));
            sgn       = int'($urandom_range(0, 1));
            s_code[i] = SW'((sgn << (SW-1)) | mag);
        end
    endtask

    task automatic test_random();
        randomize_operands();
        model_expected(1'b1, 1'b0);
        run_job(1'b1, 1'b0, 1'b0, "random_clear");
        randomize_operands();
        model_expected(1'b0, 1'b0);
        run_job(1'b0, 1'b0, 1'b0, "random_accum");
`ifdef POLMUL_SUB_EN
        randomize_operands();
        model_expected(1'b0, 1'b1);
        run_job(1'b0, 1'b1, 1'b0, "random_subtract");
`endif
    endtask

    initial begin
        test_reset();
        test_identity();
        test_shift();
        test_negate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
